// File: rtl/intv_mem_sched_if.sv
// Toggle-handshake SDRAM port between the memory scheduler and sdram_amr.
// The master side raises requests and the slave side acknowledges them.
interface intv_mem_sched_if;
  logic        req;
  logic        ack;
  logic        we;
  logic [21:0] sd_addr;
  logic [7:0]  din;
  logic [15:0] sd_dout;

  modport master (output req, sd_addr, we, din, input ack, sd_dout);
  modport slave  (input req, sd_addr, we, din, output ack, sd_dout);
endinterface

// File: rtl/intv_mem_sched.sv
// Memory-port scheduler: ioctl download writes and core reads onto two
// independent SDRAM toggle-handshake ports (ROM and cartridge).
module intv_mem_port (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        download,
  input  logic        dl_rise,
  input  logic        wr_hit,
  input  logic [21:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [15:0] rd_addr,
  input  logic        rd_stb,
  intv_mem_sched_if.master sd,
  output logic [15:0] dout,
  output logic        valid,
  output logic        wr_busy_c,
  output logic        overrun_c
);
  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

  state_t      state, state_nxt;
  logic        req, req_nxt;
  logic        we, we_nxt;
  logic [21:0] sd_addr, sd_addr_nxt;
  logic [7:0]  din, din_nxt;
  logic [15:0] dout_nxt;
  logic        valid_nxt;
  logic        pend_vld, pend_vld_nxt;
  logic [15:0] pend_addr, pend_addr_nxt;
  logic        wp_vld, wp_vld_nxt;
  logic [21:0] wp_addr, wp_addr_nxt;
  logic [7:0]  wp_data, wp_data_nxt;
  logic        stb_ok;
  logic        done;

  assign stb_ok    = rd_stb & ~download;
  assign done      = (state != IDLE) && (sd.ack == req);
  assign wr_busy_c = (state == WR_BUSY);
  assign overrun_c = wr_hit & (state == WR_BUSY);

  assign sd.req     = req;
  assign sd.we      = we;
  assign sd.sd_addr = sd_addr;
  assign sd.din     = din;

  // State and datapath registers; req resyncs to ack so reset issues nothing
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      req       <= sd.ack;
      we        <= 1'b0;
      sd_addr   <= '0;
      din       <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      wp_vld    <= 1'b0;
      wp_addr   <= '0;
      wp_data   <= '0;
    end else begin
      state     <= state_nxt;
      req       <= req_nxt;
      we        <= we_nxt;
      sd_addr   <= sd_addr_nxt;
      din       <= din_nxt;
      dout      <= dout_nxt;
      valid     <= valid_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_addr <= pend_addr_nxt;
      wp_vld    <= wp_vld_nxt;
      wp_addr   <= wp_addr_nxt;
      wp_data   <= wp_data_nxt;
    end
  end

  // Next-state: issue priority is new write, parked write, new strobe, pending read
  always_comb begin
    state_nxt     = state;
    req_nxt       = req;
    we_nxt        = we;
    sd_addr_nxt   = sd_addr;
    din_nxt       = din;
    dout_nxt      = dout;
    valid_nxt     = 1'b0;
    pend_vld_nxt  = pend_vld & ~dl_rise;
    pend_addr_nxt = pend_addr;
    wp_vld_nxt    = wp_vld;
    wp_addr_nxt   = wp_addr;
    wp_data_nxt   = wp_data;

    case (state)
      IDLE, RD_BUSY: begin
        if (state == RD_BUSY && done) begin
          dout_nxt  = sd.sd_dout;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end
        if (state == IDLE || done) begin
          if (wr_hit) begin
            sd_addr_nxt = wr_addr;
            din_nxt     = wr_data;
            we_nxt      = 1'b1;
            req_nxt     = ~req;
            state_nxt   = WR_BUSY;
          end else if (wp_vld) begin
            sd_addr_nxt = wp_addr;
            din_nxt     = wp_data;
            we_nxt      = 1'b1;
            req_nxt     = ~req;
            wp_vld_nxt  = 1'b0;
            state_nxt   = WR_BUSY;
          end else if (stb_ok) begin
            sd_addr_nxt  = 22'({rd_addr, 1'b0});
            we_nxt       = 1'b0;
            req_nxt      = ~req;
            pend_vld_nxt = 1'b0;
            state_nxt    = RD_BUSY;
          end else if (pend_vld_nxt) begin
            sd_addr_nxt  = 22'({pend_addr, 1'b0});
            we_nxt       = 1'b0;
            req_nxt      = ~req;
            pend_vld_nxt = 1'b0;
            state_nxt    = RD_BUSY;
          end
        end else begin
          // Read still in flight: park a colliding write, queue newest strobe
          if (wr_hit) begin
            wp_vld_nxt  = 1'b1;
            wp_addr_nxt = wr_addr;
            wp_data_nxt = wr_data;
          end
          if (stb_ok) begin
            pend_vld_nxt  = 1'b1;
            pend_addr_nxt = rd_addr;
          end
        end
      end
      WR_BUSY: begin
        if (done) begin
          we_nxt    = 1'b0;
          state_nxt = IDLE;
        end
        if (stb_ok) begin
          pend_vld_nxt  = 1'b1;
          pend_addr_nxt = rd_addr;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

module intv_mem_sched #(
  parameter logic [5:0] ROM_INDEX  = 6'd0,
  parameter logic [5:0] CART_INDEX = 6'd1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic [15:0] rom_addr,
  input  logic        rom_stb,
  output logic [15:0] rom_dout,
  output logic        rom_valid,
  input  logic [15:0] cart_addr,
  input  logic        cart_stb,
  output logic [15:0] cart_dout,
  output logic        cart_valid,
  intv_mem_sched_if.master rom_sd,
  intv_mem_sched_if.master cart_sd,
  output logic        err_overrun
);
  logic dl_q;
  logic dl_rise;
  logic rom_hit, cart_hit;
  logic rom_wr_busy_c, cart_wr_busy_c;
  logic rom_overrun_c, cart_overrun_c;
  logic unused_bits;

  assign unused_bits = &{1'b0, ioctl_index[7:6], ioctl_addr[24:22]};
  assign dl_rise     = ioctl_download & ~dl_q;
  assign rom_hit     = ioctl_download & ioctl_wr & (ioctl_index[5:0] == ROM_INDEX);
  assign cart_hit    = ioctl_download & ioctl_wr & (ioctl_index[5:0] == CART_INDEX);
  assign ioctl_wait  = rom_hit | cart_hit | rom_wr_busy_c | cart_wr_busy_c;

  // Download edge detect and sticky overrun flag
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      dl_q        <= ioctl_download;
      err_overrun <= err_overrun | rom_overrun_c | cart_overrun_c;
    end
  end

  intv_mem_port u_rom (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .download  (ioctl_download),
    .dl_rise   (dl_rise),
    .wr_hit    (rom_hit),
    .wr_addr   (ioctl_addr[21:0]),
    .wr_data   (ioctl_dout),
    .rd_addr   (rom_addr),
    .rd_stb    (rom_stb),
    .sd        (rom_sd),
    .dout      (rom_dout),
    .valid     (rom_valid),
    .wr_busy_c (rom_wr_busy_c),
    .overrun_c (rom_overrun_c)
  );

  intv_mem_port u_cart (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .download  (ioctl_download),
    .dl_rise   (dl_rise),
    .wr_hit    (cart_hit),
    .wr_addr   (ioctl_addr[21:0]),
    .wr_data   (ioctl_dout),
    .rd_addr   (cart_addr),
    .rd_stb    (cart_stb),
    .sd        (cart_sd),
    .dout      (cart_dout),
    .valid     (cart_valid),
    .wr_busy_c (cart_wr_busy_c),
    .overrun_c (cart_overrun_c)
  );
endmodule
